// File: rtl/jtcop_snd_pkg.sv
// rtl/jtcop_snd_pkg.sv - shared widths, defaults and FSM encoding for the sound ROM arbiter
package jtcop_snd_pkg;

  localparam int SND_CPU_AW   = 16;
  localparam int SND_PCM_AW   = 18;
  localparam int SND_SDRAM_AW = 19;

  localparam logic [SND_SDRAM_AW-1:0] SND_PCM_OFFSET = 19'h10000;
  localparam logic [3:0]              SND_STARVE_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_PCM  = 2'd2,
    ST_GAP  = 2'd3
  } snd_arb_state_e;

endpackage

// File: rtl/jtcop_snd_romarb_if.sv
// rtl/jtcop_snd_romarb_if.sv - requester and SDRAM slot signals of the sound ROM arbiter
interface jtcop_snd_romarb_if
  import jtcop_snd_pkg::*;
#(
  parameter int CPU_AW   = SND_CPU_AW,
  parameter int PCM_AW   = SND_PCM_AW,
  parameter int SDRAM_AW = SND_SDRAM_AW
) ();

  logic [CPU_AW-1:0]   cpu_addr;
  logic                cpu_cs;
  logic [7:0]          cpu_data;
  logic                cpu_ok;
  logic [PCM_AW-1:0]   pcm_addr;
  logic                pcm_cs;
  logic [7:0]          pcm_data;
  logic                pcm_ok;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_cs;
  logic [7:0]          sdram_data;
  logic                sdram_ok;
  logic                pcm_busy;

  // slave is the arbiter; master is the surrounding sound subsystem plus SDRAM slot
  modport slave (
    input  cpu_addr, cpu_cs, pcm_addr, pcm_cs, sdram_data, sdram_ok,
    output cpu_data, cpu_ok, pcm_data, pcm_ok, sdram_addr, sdram_cs, pcm_busy
  );

  modport master (
    output cpu_addr, cpu_cs, pcm_addr, pcm_cs, sdram_data, sdram_ok,
    input  cpu_data, cpu_ok, pcm_data, pcm_ok, sdram_addr, sdram_cs, pcm_busy
  );

endinterface

// File: rtl/jtcop_snd_romarb_ch.sv
// rtl/jtcop_snd_romarb_ch.sv - one-byte tag/data/valid register with registered ok
// JTCOP_SNDARB_CACHE_EN keeps the valid flag alive while cs is low.
module jtcop_snd_romarb_ch #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic          cs_i,
  input  logic          start_i,
  input  logic          capture_i,
  input  logic [7:0]    sdram_data_i,
  output logic [7:0]    data_o,
  output logic          ok_o,
  output logic          pending_o
);

`ifdef JTCOP_SNDARB_CACHE_EN
  localparam bit KEEP_VALID = 1'b1;
`else
  localparam bit KEEP_VALID = 1'b0;
`endif

  logic [AW-1:0] tag_q, tag_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ok_q, ok_d;
  logic          hit;

  assign hit       = cs_i & valid_q & (addr_i == tag_q);
  assign pending_o = cs_i & ~hit;
  assign data_o    = data_q;
  assign ok_o      = ok_q;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    ok_d    = hit;
    if (start_i) begin
      tag_d   = addr_i;
      valid_d = 1'b0;
    end
    if (capture_i) begin
      data_d  = sdram_data_i;
      valid_d = 1'b1;
    end
    // dropping cs must win over a same-cycle capture so the next cs starts a fresh fetch
    if (!cs_i && !KEEP_VALID) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
    end
  end

endmodule

// File: rtl/jtcop_snd_romarb.sv
// rtl/jtcop_snd_romarb.sv - shares one 8-bit SDRAM slot between sound CPU ROM and ADPCM ROM
// Optional JTCOP_SNDARB_CACHE_EN (in the channel) keeps fetched bytes valid across cs drops.
module jtcop_snd_romarb
  import jtcop_snd_pkg::*;
#(
  parameter int                  CPU_AW     = SND_CPU_AW,
  parameter int                  PCM_AW     = SND_PCM_AW,
  parameter int                  SDRAM_AW   = SND_SDRAM_AW,
  parameter logic [SDRAM_AW-1:0] PCM_OFFSET = SND_PCM_OFFSET,
  parameter logic [3:0]          STARVE_MAX = SND_STARVE_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  jtcop_snd_romarb_if.slave  bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CPU  = ST_CPU;
  localparam logic [1:0] S_PCM  = ST_PCM;
  localparam logic [1:0] S_GAP  = ST_GAP;

  logic [1:0]          state_q, state_d;
  logic                first_q, first_d;
  logic [3:0]          starve_q, starve_d;
  logic [SDRAM_AW-1:0] saddr_q, saddr_d;
  logic                scs_q, scs_d;

  logic cpu_pend, pcm_pend;
  logic cpu_start, pcm_start;
  logic cpu_cap, pcm_cap;

  jtcop_snd_romarb_ch #(.AW(CPU_AW)) u_cpu_ch (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_i       (bus.cpu_addr),
    .cs_i         (bus.cpu_cs),
    .start_i      (cpu_start),
    .capture_i    (cpu_cap),
    .sdram_data_i (bus.sdram_data),
    .data_o       (bus.cpu_data),
    .ok_o         (bus.cpu_ok),
    .pending_o    (cpu_pend)
  );

  jtcop_snd_romarb_ch #(.AW(PCM_AW)) u_pcm_ch (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_i       (bus.pcm_addr),
    .cs_i         (bus.pcm_cs),
    .start_i      (pcm_start),
    .capture_i    (pcm_cap),
    .sdram_data_i (bus.sdram_data),
    .data_o       (bus.pcm_data),
    .ok_o         (bus.pcm_ok),
    .pending_o    (pcm_pend)
  );

  assign bus.sdram_addr = saddr_q;
  assign bus.sdram_cs   = scs_q;
  assign bus.pcm_busy   = (state_q == S_PCM);

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    starve_d  = starve_q;
    saddr_d   = saddr_q;
    scs_d     = scs_q;
    cpu_start = 1'b0;
    pcm_start = 1'b0;
    cpu_cap   = 1'b0;
    pcm_cap   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_pend && !(pcm_pend && starve_q >= STARVE_MAX)) begin
          state_d   = S_CPU;
          cpu_start = 1'b1;
          first_d   = 1'b1;
          scs_d     = 1'b1;
          saddr_d   = SDRAM_AW'(bus.cpu_addr);
        end else if (pcm_pend) begin
          state_d   = S_PCM;
          pcm_start = 1'b1;
          first_d   = 1'b1;
          scs_d     = 1'b1;
          saddr_d   = PCM_OFFSET + SDRAM_AW'(bus.pcm_addr);
        end
      end
      S_CPU, S_PCM: begin
        // the slot's ok in the first cycle still belongs to the previous address
        first_d = 1'b0;
        if (!first_q && bus.sdram_ok) begin
          cpu_cap = (state_q == S_CPU);
          pcm_cap = (state_q == S_PCM);
          scs_d   = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!bus.pcm_cs || pcm_start) begin
      starve_d = '0;
    end else if (pcm_pend && state_q != S_PCM && starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      first_q  <= 1'b0;
      starve_q <= '0;
      saddr_q  <= '0;
      scs_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      starve_q <= starve_d;
      saddr_q  <= saddr_d;
      scs_q    <= scs_d;
    end
  end

endmodule

// File: tb/tb_jtcop_snd_romarb.sv
// tb/tb_jtcop_snd_romarb.sv - randomized and directed checks of jtcop_snd_romarb against a cycle model
module tb_jtcop_snd_romarb;

`ifdef JTCOP_SNDARB_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtcop_snd_romarb_if bus ();
  jtcop_snd_romarb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // reference model: who owns the slot, how long it has owned it, and per-channel byte stores
  int         m_owner;   // 0 free, 1 cpu, 2 pcm, 3 mandatory idle gap
  int         m_age;
  logic [15:0] m_ctag;
  logic [17:0] m_ptag;
  logic        m_cval, m_pval, m_cok, m_pok;
  logic [7:0]  m_cdat, m_pdat;
  int          m_starve;
  logic [18:0] m_saddr;
  logic        m_scs;

  // stimulus and SDRAM slot behaviour
  logic [15:0] s_caddr = '0;
  logic [17:0] s_paddr = '0;
  logic        s_ccs = 1'b0, s_pcs = 1'b0;
  int          fixed_lat = 2;
  bit          junk_all = 0, junk_rand = 0, ovr_en = 0;
  logic [7:0]  ovr_data = '0;
  bit          chg_on_ok = 0;
  logic [15:0] chg_addr = '0;
  int          sl_age = 0, sl_lat = 1;
  logic        sl_prev_cs = 1'b0;

  // observations of the DUT for the directed literal checks
  logic        obs_prev_cs = 1'b0;
  int          n_rise = 0, n_prise = 0;
  logic [18:0] last_rise_addr = '0;
  bit          saw_busy = 0;

  function automatic logic [7:0] mem(logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h5A;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_owner = 0; m_age = 0; m_ctag = '0; m_ptag = '0;
    m_cval = 0; m_pval = 0; m_cok = 0; m_pok = 0;
    m_cdat = '0; m_pdat = '0; m_starve = 0; m_saddr = '0; m_scs = 0;
  endfunction

  function automatic void check_outputs();
    chk("cpu_ok", 32'(bus.cpu_ok), 32'(m_cok));
    chk("cpu_data", 32'(bus.cpu_data), 32'(m_cdat));
    chk("pcm_ok", 32'(bus.pcm_ok), 32'(m_pok));
    chk("pcm_data", 32'(bus.pcm_data), 32'(m_pdat));
    chk("sdram_cs", 32'(bus.sdram_cs), 32'(m_scs));
    chk("sdram_addr", 32'(bus.sdram_addr), 32'(m_saddr));
    chk("pcm_busy", 32'(bus.pcm_busy), 32'(m_owner == 2));
  endfunction

  function automatic void slot_drive();
    if (bus.sdram_cs && !sl_prev_cs) begin
      sl_age = 0;
      sl_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
    end else if (bus.sdram_cs) begin
      sl_age++;
    end
    sl_prev_cs = bus.sdram_cs;
    if (bus.sdram_cs && sl_age >= 1 && sl_age == sl_lat) begin
      bus.sdram_ok   = 1'b1;
      bus.sdram_data = ovr_en ? ovr_data : mem(bus.sdram_addr);
    end else if ((!bus.sdram_cs || sl_age == 0) &&
                 (junk_all || (junk_rand && $urandom_range(0, 3) == 0))) begin
      bus.sdram_ok   = 1'b1;
      bus.sdram_data = ovr_en ? ~ovr_data : 8'($urandom);
    end else begin
      bus.sdram_ok   = 1'b0;
      bus.sdram_data = 8'($urandom);
    end
  endfunction

  function automatic void model_step();
    logic hc, hp, pc, pp, grant_c, grant_p, cap;
    int ns;
    hc = bus.cpu_cs && m_cval && (bus.cpu_addr == m_ctag);
    hp = bus.pcm_cs && m_pval && (bus.pcm_addr == m_ptag);
    pc = bus.cpu_cs && !hc;
    pp = bus.pcm_cs && !hp;
    grant_c = 0; grant_p = 0; cap = 0;
    if (m_owner == 0) begin
      if (pc && !(pp && m_starve >= 15)) grant_c = 1;
      else if (pp) grant_p = 1;
    end else if (m_owner == 1 || m_owner == 2) begin
      cap = (m_age >= 1) && bus.sdram_ok;
    end
    if (!bus.pcm_cs || grant_p) ns = 0;
    else if (pp && m_owner != 2) ns = (m_starve >= 15) ? 15 : m_starve + 1;
    else ns = m_starve;
    m_starve = ns;
    m_cok = hc;
    m_pok = hp;
    if (grant_c) begin
      m_owner = 1; m_age = 0; m_ctag = bus.cpu_addr; m_cval = 0;
      m_saddr = {3'b000, bus.cpu_addr}; m_scs = 1;
    end else if (grant_p) begin
      m_owner = 2; m_age = 0; m_ptag = bus.pcm_addr; m_pval = 0;
      m_saddr = 19'(32'h10000 + 32'(bus.pcm_addr)); m_scs = 1;
    end else if (cap) begin
      if (m_owner == 1) begin m_cdat = bus.sdram_data; m_cval = 1; end
      else begin m_pdat = bus.sdram_data; m_pval = 1; end
      m_scs = 0; m_owner = 3;
    end else if (m_owner == 3) begin
      m_owner = 0;
    end else if (m_owner != 0) begin
      m_age++;
    end
    if (!CACHE && !bus.cpu_cs) m_cval = 0;
    if (!CACHE && !bus.pcm_cs) m_pval = 0;
  endfunction

  // one clock: observe and compare at the negedge, drive next inputs, advance the model
  task automatic step();
    if (bus.sdram_cs && !obs_prev_cs) begin
      n_rise++;
      last_rise_addr = bus.sdram_addr;
      if (bus.pcm_busy) n_prise++;
    end
    obs_prev_cs = bus.sdram_cs;
    if (bus.pcm_busy) saw_busy = 1;
    check_outputs();
    slot_drive();
    if (chg_on_ok && bus.sdram_ok && bus.sdram_cs && sl_age >= 1) begin
      s_caddr = chg_addr;
      chg_on_ok = 0;
    end
    bus.cpu_cs = s_ccs; bus.cpu_addr = s_caddr;
    bus.pcm_cs = s_pcs; bus.pcm_addr = s_paddr;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_steps(int n);
    s_ccs = 0; s_pcs = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c0, p0;
    bit early;
    logic [15:0] caddrs [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h1234};
    logic [17:0] paddrs [4] = '{18'h00000, 18'h00001, 18'h2AAAA, 18'h3FFFF};

    model_reset();
    bus.cpu_cs = 0; bus.cpu_addr = '0; bus.pcm_cs = 0; bus.pcm_addr = '0;
    bus.sdram_ok = 0; bus.sdram_data = '0;
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    idle_steps(2);

    // CPU-only fetch
    fixed_lat = 3; ovr_en = 1; ovr_data = 8'hA5;
    s_ccs = 1; s_caddr = 16'h1234;
    for (int i = 0; i < 20 && !bus.cpu_ok; i++) step();
    chk("cpu_only_addr", 32'(last_rise_addr), 32'h01234);
    chk("cpu_only_ok", 32'(bus.cpu_ok), 32'd1);
    chk("cpu_only_data", 32'(bus.cpu_data), 32'hA5);
    idle_steps(3);

    // PCM-only fetch
    saw_busy = 0; ovr_data = 8'h3C; fixed_lat = 2;
    s_pcs = 1; s_paddr = 18'h00010;
    for (int i = 0; i < 20 && !bus.pcm_ok; i++) step();
    chk("pcm_only_addr", 32'(last_rise_addr), 32'h10010);
    chk("pcm_only_busy", 32'(saw_busy), 32'd1);
    chk("pcm_only_ok", 32'(bus.pcm_ok), 32'd1);
    chk("pcm_only_data", 32'(bus.pcm_data), 32'h3C);
    idle_steps(3);

    // stale sdram_ok held high across the transaction start
    junk_all = 1; ovr_data = 8'h5A; fixed_lat = 2;
    s_ccs = 1; s_caddr = 16'h2222;
    for (int i = 0; i < 20 && !bus.cpu_ok; i++) step();
    chk("stale_ok_data", 32'(bus.cpu_data), 32'h5A);
    junk_all = 0; ovr_en = 0;
    idle_steps(3);

    // address changes on the very cycle the slot answers
    early = 0; fixed_lat = 2; chg_on_ok = 1; chg_addr = 16'h0101;
    s_ccs = 1; s_caddr = 16'h0100;
    for (int i = 0; i < 40 && !(!chg_on_ok && bus.cpu_ok); i++) begin
      if (bus.cpu_ok && bus.cpu_data == 8'h5B) early = 1;
      step();
    end
    chk("addr_chg_no_stale_ok", 32'(early), 32'd0);
    chk("addr_chg_refetch_addr", 32'(last_rise_addr), 32'h00101);
    chk("addr_chg_ok", 32'(bus.cpu_ok), 32'd1);
    chk("addr_chg_data", 32'(bus.cpu_data), 32'h5A);

    // re-request of the same address after cs drops
    s_ccs = 0; step(); step();
    c0 = n_rise;
    s_ccs = 1;
    step();
    step();
    chk("rereq_ok_next", 32'(bus.cpu_ok), 32'(CACHE));
    for (int i = 0; i < 12; i++) step();
    chk("rereq_fetches", 32'(n_rise - c0), CACHE ? 32'd0 : 32'd1);
    idle_steps(3);

    // contention: CPU keeps missing, ADPCM is promoted once starved
    fixed_lat = 1; s_paddr = 18'h00020; s_caddr = 16'h4000;
    c0 = n_rise; p0 = n_prise;
    s_ccs = 1; s_pcs = 1;
    for (int i = 0; i < 80 && n_prise == p0; i++) begin
      s_caddr = s_caddr + 16'd1;
      step();
    end
    chk("contention_pcm_granted", 32'(n_prise - p0), 32'd1);
    chk("contention_cpu_first", 32'(n_rise - c0 - 1), 32'd4);
    idle_steps(3);

    // randomized traffic
    fixed_lat = 0; junk_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) s_ccs = ~s_ccs;
      if ($urandom_range(0, 7) == 0) s_pcs = ~s_pcs;
      if ($urandom_range(0, 3) == 0) s_caddr = caddrs[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) s_paddr = paddrs[$urandom_range(0, 3)];
      step();
    end
    junk_rand = 0; fixed_lat = 3;
    idle_steps(3);

    // reset in the middle of a transaction
    s_ccs = 1; s_caddr = 16'h7777;
    for (int i = 0; i < 10 && !bus.sdram_cs; i++) step();
    chk("mid_rst_cs_before", 32'(bus.sdram_cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_async", 32'(bus.sdram_cs), 32'd0);
    chk("mid_rst_addr_async", 32'(bus.sdram_addr), 32'd0);
    model_reset();
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
